// File: rtl/mdio_phy_ctrl.sv
// MDIO sequencer: soft-resets the PHY, polls BMSR/speed status and shares the bit-shift engine with a host port.
// States: INIT_WAIT reset delay | SRST_WR/SRST_RD BMCR soft reset | IDLE poll timer | BMSR_RD/SPD_RD status poll | HOST host access
module mdio_phy_ctrl #(
  parameter logic [4:0]  PHY_ADDR      = 5'd1,
  parameter logic [23:0] RST_WAIT      = 24'd250000,
  parameter logic [23:0] POLL_INTERVAL = 24'd250000,
  parameter logic [7:0]  MAX_POLL      = 8'd100,
  parameter logic [4:0]  SPEED_REG     = 5'h11
) (
  input  logic        mdc,
  input  logic        rst,
  output logic        mdio_start,
  output logic        mdio_if_read,
  output logic [4:0]  mdio_phy_addr,
  output logic [4:0]  mdio_reg_addr,
  output logic [15:0] mdio_wrdata,
  input  logic        mdio_done,
  input  logic [15:0] mdio_rddata,
  input  logic        host_req,
  input  logic        host_rd,
  input  logic [4:0]  host_reg,
  input  logic [15:0] host_wdata,
  output logic        host_ack,
  output logic [15:0] host_rdata,
  output logic        init_done,
  output logic        init_err,
  output logic        link_up,
  output logic [1:0]  speed,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_INIT_WAIT,
    S_SRST_WR,
    S_SRST_RD,
    S_IDLE,
    S_BMSR_RD,
    S_SPD_RD,
    S_HOST
  } state_t;

  state_t      state_q, state_d;
  logic [23:0] timer_q, timer_d, timer_sat;
  logic [7:0]  poll_cnt_q, poll_cnt_d;
  logic        start_q, start_d;
  logic        busy_q, busy_d;
  logic        if_read_q, if_read_d;
  logic [4:0]  phy_addr_q, phy_addr_d;
  logic [4:0]  reg_addr_q, reg_addr_d;
  logic [15:0] wrdata_q, wrdata_d;
  logic        host_ack_q, host_ack_d;
  logic [15:0] host_rdata_q, host_rdata_d;
  logic        init_done_q, init_done_d;
  logic        init_err_q, init_err_d;
  logic        link_up_q, link_up_d;
  logic [1:0]  speed_q, speed_d;

  logic        issue;
  logic        cmd_rd;
  logic [4:0]  cmd_reg;
  logic [15:0] cmd_wdata;
  logic        xfer_done;

  assign xfer_done = busy_q && mdio_done;

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    poll_cnt_d   = poll_cnt_q;
    start_d      = 1'b0;
    busy_d       = busy_q;
    if_read_d    = if_read_q;
    phy_addr_d   = PHY_ADDR;
    reg_addr_d   = reg_addr_q;
    wrdata_d     = wrdata_q;
    host_ack_d   = 1'b0;
    host_rdata_d = host_rdata_q;
    init_done_d  = init_done_q;
    init_err_d   = init_err_q;
    link_up_d    = link_up_q;
    speed_d      = speed_q;
    issue        = 1'b0;
    cmd_rd       = 1'b1;
    cmd_reg      = 5'd0;
    cmd_wdata    = 16'h0000;
    timer_sat    = (timer_q >= POLL_INTERVAL) ? timer_q : timer_q + 24'd1;

    case (state_q)
      S_INIT_WAIT: begin
        if (timer_q >= RST_WAIT) begin
          timer_d = 24'd0;
          state_d = S_SRST_WR;
        end else begin
          timer_d = timer_q + 24'd1;
        end
      end
      S_SRST_WR: begin
        cmd_rd    = 1'b0;
        cmd_wdata = 16'h9140;
        issue     = !busy_q;
        if (xfer_done) state_d = S_SRST_RD;
      end
      S_SRST_RD: begin
        issue = !busy_q;
        if (xfer_done) begin
          if (!mdio_rddata[15]) begin
            init_done_d = 1'b1;
            timer_d     = 24'd0;
            state_d     = S_IDLE;
          end else if (poll_cnt_q < MAX_POLL) begin
            poll_cnt_d = poll_cnt_q + 8'd1;
          end else begin
            init_err_d  = 1'b1;
            init_done_d = 1'b1;
            timer_d     = 24'd0;
            state_d     = S_IDLE;
          end
        end
      end
      S_IDLE: begin
        timer_d = timer_sat;
        // host_ack_q masks the request level still present in the ack cycle
        if (host_req && !host_ack_q) state_d = S_HOST;
        else if (timer_q >= POLL_INTERVAL) state_d = S_BMSR_RD;
      end
      S_BMSR_RD: begin
        cmd_reg = 5'd1;
        issue   = !busy_q;
        if (xfer_done) begin
          link_up_d = mdio_rddata[2];
          if (!mdio_rddata[2]) begin
            speed_d = 2'b00;
            timer_d = 24'd0;
            state_d = S_IDLE;
          end else begin
            state_d = S_SPD_RD;
          end
        end
      end
      S_SPD_RD: begin
        cmd_reg = SPEED_REG;
        issue   = !busy_q;
        if (xfer_done) begin
          speed_d = (mdio_rddata[15:14] == 2'b11) ? 2'b00 : mdio_rddata[15:14];
          timer_d = 24'd0;
          state_d = S_IDLE;
        end
      end
      S_HOST: begin
        timer_d   = timer_sat;
        cmd_rd    = host_rd;
        cmd_reg   = host_reg;
        cmd_wdata = host_wdata;
        issue     = !busy_q;
        if (xfer_done) begin
          if (if_read_q) host_rdata_d = mdio_rddata;
          host_ack_d = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_INIT_WAIT;
    endcase

    // busy drops on the done edge, so the earliest next start lands 2 cycles after done
    if (xfer_done) busy_d = 1'b0;
    if (issue) begin
      start_d    = 1'b1;
      busy_d     = 1'b1;
      if_read_d  = cmd_rd;
      reg_addr_d = cmd_reg;
      wrdata_d   = cmd_wdata;
    end
  end

  always_ff @(posedge mdc) begin
    if (rst) begin
      state_q      <= S_INIT_WAIT;
      timer_q      <= 24'd0;
      poll_cnt_q   <= 8'd0;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
      if_read_q    <= 1'b0;
      phy_addr_q   <= 5'd0;
      reg_addr_q   <= 5'd0;
      wrdata_q     <= 16'h0000;
      host_ack_q   <= 1'b0;
      host_rdata_q <= 16'h0000;
      init_done_q  <= 1'b0;
      init_err_q   <= 1'b0;
      link_up_q    <= 1'b0;
      speed_q      <= 2'b00;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      poll_cnt_q   <= poll_cnt_d;
      start_q      <= start_d;
      busy_q       <= busy_d;
      if_read_q    <= if_read_d;
      phy_addr_q   <= phy_addr_d;
      reg_addr_q   <= reg_addr_d;
      wrdata_q     <= wrdata_d;
      host_ack_q   <= host_ack_d;
      host_rdata_q <= host_rdata_d;
      init_done_q  <= init_done_d;
      init_err_q   <= init_err_d;
      link_up_q    <= link_up_d;
      speed_q      <= speed_d;
    end
  end

  assign mdio_start    = start_q;
  assign mdio_if_read  = if_read_q;
  assign mdio_phy_addr = phy_addr_q;
  assign mdio_reg_addr = reg_addr_q;
  assign mdio_wrdata   = wrdata_q;
  assign host_ack      = host_ack_q;
  assign host_rdata    = host_rdata_q;
  assign init_done     = init_done_q;
  assign init_err      = init_err_q;
  assign link_up       = link_up_q;
  assign speed         = speed_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_mdio_phy_ctrl.sv
// Directed bench for mdio_phy_ctrl with a behavioural 64-cycle MDIO shifter and PHY register model.
module tb_mdio_phy_ctrl;

  localparam int POLL = 20;

  logic        mdc = 1'b0;
  logic        rst = 1'b1;
  logic        mdio_start, mdio_if_read;
  logic [4:0]  mdio_phy_addr, mdio_reg_addr;
  logic [15:0] mdio_wrdata;
  logic        mdio_done = 1'b0;
  logic [15:0] mdio_rddata = 16'hBAD0;
  logic        host_req = 1'b0;
  logic        host_rd = 1'b0;
  logic [4:0]  host_reg = 5'd0;
  logic [15:0] host_wdata = 16'h0000;
  logic        host_ack;
  logic [15:0] host_rdata;
  logic        init_done, init_err, link_up, busy;
  logic [1:0]  speed;

  mdio_phy_ctrl #(
    .PHY_ADDR(5'd1), .RST_WAIT(24'd10), .POLL_INTERVAL(24'(POLL)),
    .MAX_POLL(8'd5), .SPEED_REG(5'h11)
  ) dut (
    .mdc(mdc), .rst(rst),
    .mdio_start(mdio_start), .mdio_if_read(mdio_if_read), .mdio_phy_addr(mdio_phy_addr),
    .mdio_reg_addr(mdio_reg_addr), .mdio_wrdata(mdio_wrdata),
    .mdio_done(mdio_done), .mdio_rddata(mdio_rddata),
    .host_req(host_req), .host_rd(host_rd), .host_reg(host_reg), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata),
    .init_done(init_done), .init_err(init_err), .link_up(link_up), .speed(speed), .busy(busy)
  );

  always #5 mdc = ~mdc;

  int cyc = 0;
  always @(posedge mdc) cyc <= cyc + 1;

  // PHY register contents, set by the stimulus
  int          bmcr_clear_at = 3;
  logic [15:0] bmsr_val = 16'h0004;
  logic [15:0] spd_val  = 16'h8000;
  int          log_base = 0;

  // shifter model state
  logic [21:0] tlog[$];
  logic [21:0] cur = '0;
  int rem = 0;
  int last_done = -100;
  int bmcr_rd_cnt = 0;
  int gap_bad = 0, field_bad = 0, phy_bad = 0;
  int ack_cnt = 0;

  always @(negedge mdc) begin
    mdio_done   = 1'b0;
    mdio_rddata = 16'hBAD0;
    if (rst) begin
      rem         = 0;
      last_done   = -100;
      bmcr_rd_cnt = 0;
    end else begin
      if (rem != 0) begin
        if ({mdio_if_read, mdio_reg_addr, mdio_wrdata} !== cur) field_bad++;
        rem--;
        if (rem == 0) begin
          mdio_done = 1'b1;
          last_done = cyc;
          if (cur[21]) begin
            case (cur[20:16])
              5'd0: begin
                bmcr_rd_cnt++;
                mdio_rddata = (bmcr_clear_at != 0 && bmcr_rd_cnt >= bmcr_clear_at) ? 16'h1140 : 16'h9140;
              end
              5'd1:    mdio_rddata = bmsr_val;
              5'h11:   mdio_rddata = spd_val;
              5'd2:    mdio_rddata = 16'h001C;
              default: mdio_rddata = 16'h0000;
            endcase
          end
        end
      end
      if (mdio_start === 1'b1) begin
        if (rem != 0 || cyc < last_done + 2) gap_bad++;
        if (mdio_phy_addr !== 5'd1) phy_bad++;
        cur = {mdio_if_read, mdio_reg_addr, mdio_wrdata};
        tlog.push_back(cur);
        rem = 64;
      end
    end
  end

  always @(negedge mdc) if (!rst && host_ack === 1'b1) ack_cnt++;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ent(input logic rd, input logic [4:0] r, input logic [15:0] wd);
    return {42'd0, rd, r, wd};
  endfunction

  function automatic int lsize();
    return tlog.size() - log_base;
  endfunction

  function automatic logic [63:0] get(input int i);
    if (i < lsize()) return {42'd0, tlog[log_base + i]};
    return '1;
  endfunction

  function automatic logic [63:0] all_outs();
    return {13'd0, mdio_start, mdio_if_read, mdio_phy_addr, mdio_reg_addr, mdio_wrdata,
            host_ack, host_rdata, init_done, init_err, link_up, speed, busy};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge mdc);
  endtask

  task automatic wait_log(input int n, input string tag);
    int k = 0;
    while (lsize() < n && k < 2000) begin @(negedge mdc); k++; end
    check(tag, 64'(lsize() >= n), 64'd1);
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy !== 1'b0 && k < 200) begin @(negedge mdc); k++; end
    check(tag, 64'(busy), 64'd0);
  endtask

  task automatic wait_init(input string tag);
    int k = 0;
    while (init_done !== 1'b1 && k < 3000) begin @(negedge mdc); k++; end
    check(tag, 64'(init_done), 64'd1);
  endtask

  task automatic wait_ack(input string tag);
    int k = 0;
    while (host_ack !== 1'b1 && k < 500) begin @(negedge mdc); k++; end
    check(tag, 64'(host_ack), 64'd1);
    host_req = 1'b0;
  endtask

  initial begin
    int bmsr_done;
    int rd0;

    // reset, with a host write already pending
    host_req = 1'b1; host_rd = 1'b0; host_reg = 5'd4; host_wdata = 16'h01E1;
    tick(3);
    check("reset_outputs", all_outs(), 64'd0);
    rst = 1'b0;
    tick(5);
    check("no_txn_in_init_wait", 64'(lsize()), 64'd0);

    // BMCR clears on the 3rd read; host must wait for init_done
    wait_init("init_done_3rd_read");
    check("init_txn_count", 64'(lsize()), 64'd4);
    check("srst_write", get(0), ent(1'b0, 5'd0, 16'h9140));
    check("bmcr_read_1", get(1), ent(1'b1, 5'd0, 16'h0000));
    check("bmcr_read_3", get(3), ent(1'b1, 5'd0, 16'h0000));
    check("init_err_clear", 64'(init_err), 64'd0);

    wait_ack("host_wr_ack");
    check("host_write_txn", get(4), ent(1'b0, 5'd4, 16'h01E1));
    check("host_rdata_after_write", 64'(host_rdata), 64'd0);

    // link up at 1000M
    wait_log(7, "spd_read_started");
    wait_idle("spd_read_done");
    check("bmsr_read", get(5), ent(1'b1, 5'd1, 16'h0000));
    check("spd_read", get(6), ent(1'b1, 5'h11, 16'h0000));
    check("link_up_1", 64'(link_up), 64'd1);
    check("speed_1000", 64'(speed), 64'd2);

    // link drops: no speed register read
    bmsr_val = 16'h0000;
    wait_log(8, "bmsr2_started");
    wait_idle("bmsr2_done");
    bmsr_done = last_done;
    check("bmsr2_read", get(7), ent(1'b1, 5'd1, 16'h0000));
    check("link_down", 64'(link_up), 64'd0);
    check("speed_down", 64'(speed), 64'd0);
    tick(10);
    check("no_spd_read_on_link_down", 64'(lsize()), 64'd8);

    // host read arrives in the cycle the poll timer expires
    while (cyc < bmsr_done + POLL + 1) @(negedge mdc);
    check("no_poll_before_tie", 64'(lsize()), 64'd8);
    host_req = 1'b1; host_rd = 1'b1; host_reg = 5'd2; host_wdata = 16'h0000;
    wait_ack("host_rd_ack");
    check("host_first_on_tie", get(8), ent(1'b1, 5'd2, 16'h0000));
    check("host_rdata", 64'(host_rdata), 64'h001C);
    wait_log(10, "poll_after_host");
    check("bmsr_after_host", get(9), ent(1'b1, 5'd1, 16'h0000));
    check("host_ack_pulses", 64'(ack_cnt), 64'd2);

    // BMCR stuck: 1 + MAX_POLL reads then error
    @(negedge mdc);
    rst = 1'b1;
    tick(3);
    log_base = tlog.size();
    bmcr_clear_at = 0;
    bmsr_val = 16'h0004;
    spd_val  = 16'h4000;
    rst = 1'b0;
    wait_init("init_done_stuck");
    rd0 = 0;
    for (int i = 0; i < lsize(); i++) if (get(i) == ent(1'b1, 5'd0, 16'h0000)) rd0++;
    check("stuck_bmcr_reads", 64'(rd0), 64'd6);
    check("init_err_set", 64'(init_err), 64'd1);
    wait_log(9, "poll_after_stuck");
    wait_idle("poll_after_stuck_done");
    check("speed_100", 64'(speed), 64'd1);
    check("link_up_2", 64'(link_up), 64'd1);

    // reset in the middle of a BMSR read
    wait_log(10, "bmsr_for_reset");
    tick(20);
    check("busy_mid_bmsr", 64'(busy), 64'd1);
    rst = 1'b1;
    tick(1);
    check("outputs_zero_after_rst", all_outs(), 64'd0);
    log_base = tlog.size();
    tick(2);
    rst = 1'b0;
    tick(5);
    check("restart_in_init_wait", 64'(lsize()), 64'd0);
    wait_log(1, "restart_first_txn");
    check("restart_srst_write", get(0), ent(1'b0, 5'd0, 16'h9140));

    check("start_gap_violations", 64'(gap_bad), 64'd0);
    check("field_instability", 64'(field_bad), 64'd0);
    check("phy_addr_errors", 64'(phy_bad), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached (observed no finish, expected finish)");
    $fatal(1, "watchdog");
  end

endmodule
